cnt_disp_scan: RTL and testbench
================================

CNT_DISP_SCAN -- requirements
Module: cnt_disp_scan

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 4, clocks per displayed digit; legal range 2..255.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port mr  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port q_in  input  4  low-digit count from the upstream 4-bit up/down counter.
REQ-005 SHALL have port co_in  input  1  carry/borrow from the upstream counter; level may be held for several cycles.
REQ-006 SHALL have port up_dn  input  1  upstream count direction; 1 = up (co_in is carry), 0 = down (co_in is borrow).
REQ-007 SHALL have port clr  input  1  synchronous clear of the high digit and overflow flag, active-high.
REQ-008 SHALL have port seg  output  7  segment drive, active-high; seg[6]=a through seg[0]=g.
REQ-009 SHALL have port dig_sel  output  2  digit enable, one-hot active-high; 01 = low digit, 10 = high digit.
REQ-010 SHALL have port hi  output  4  high-digit value.
REQ-011 SHALL have port ovf  output  1  sticky flag set on any high-digit wrap.

Function
REQ-012 SHALL register q_in, co_in and up_dn every cycle into q_r, co_r and ud_r (one-cycle input stage).
REQ-013 SHALL keep co_d, a one-cycle-delayed copy of co_r; co_rise = co_r AND NOT co_d.
REQ-014 SHALL update hi once per co_rise only; a co_in level held N cycles counts once.
REQ-015 On co_rise with ud_r=1: hi <= hi+1 mod 16; on the 15->0 transition ovf <= 1.
REQ-016 On co_rise with ud_r=0: hi <= hi-1 mod 16; on the 0->15 transition ovf <= 1.
REQ-017 Latency: hi changes on the 2nd rising clk edge after the edge that first samples co_in high.
REQ-018 clr=1 SHALL force hi <= 0 and ovf <= 0 and SHALL take priority over a co_rise in the same cycle.
REQ-019 Once set, ovf SHALL be cleared only by clr or mr.
REQ-020 SHALL run a scan divider div (8 bits) 0..SCAN_DIV-1; at SCAN_DIV-1 it returns to 0 and digit index idx toggles.
REQ-021 dig_sel SHALL be registered: 01 when idx=0, 10 when idx=1; never 11.
REQ-022 seg SHALL be registered as the decode of q_r when idx=0, or of hi when idx=1, and is aligned with dig_sel in the same cycle.
REQ-023 Hex decode (abcdefg) SHALL be as follows.
- 0=1111110, 1=0110000, 2=1101101, 3=1111001
- 4=0110011, 5=1011011, 6=1011111, 7=1110000
- 8=1111111, 9=1111011, A=1110111, b=0011111
- C=1001110, d=0111101, E=1001111, F=1000111
REQ-024 Latency q_in -> seg SHALL be 2 clk edges while idx=0 is held.
REQ-025 A co_rise and a digit switch in the same cycle SHALL both take effect; seg reflects hi's pre-update value that cycle.

Reset
REQ-026 mr=0 SHALL immediately, without a clock edge, clear all state:
- q_r=0, co_r=0, co_d=0, ud_r=0
- hi=0, ovf=0, div=0, idx=0
- seg=0000000 (blank), dig_sel=00
REQ-027 On the first edge after mr deasserts: dig_sel=01, seg=1111110 (decode of q_r=0).
REQ-028 mr asserted mid-scan or mid-co pulse SHALL abort everything; a co_in still high at release SHALL NOT count (co_d is loaded before any edge can be detected). No partial update survives.

Verification
REQ-029 Held carry: up_dn=1, hi=2, co_in high for 5 cycles -> hi=3 exactly, at the 2nd edge after sampling; ovf=0.
REQ-030 Wrap and sticky: hi=15, up_dn=1, co pulse -> hi=0, ovf=1; then up_dn=0, co pulse -> hi=15, ovf stays 1; then clr=1 -> hi=0, ovf=0.
REQ-031 Priority: clr=1 in the same cycle as co_rise with hi=7 -> hi=0, ovf=0.
REQ-032 Scan: SCAN_DIV=4, q_in=3, hi=A -> dig_sel alternates 01/10 every 4 cycles; seg=1111001 with 01 and 1110111 with 10.
REQ-033 Latency: idx=0 held, q_in 3->7 -> seg becomes 1110000 exactly 2 edges later.
REQ-034 Async reset: hi=5, ovf=1, mr pulled low between clk edges -> seg=0, dig_sel=00, hi=0, ovf=0 before the next edge; co_in held high through release -> hi stays 0.

Source files
------------

// File: rtl/cnt_disp_scan.sv
// High digit of a two-digit up/down counter with multiplexed
// 7-segment scan of the upstream low digit and the local high digit.
module cnt_disp_scan #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       mr,
  input  logic [3:0] q_in,
  input  logic       co_in,
  input  logic       up_dn,
  input  logic       clr,
  output logic [6:0] seg,
  output logic [1:0] dig_sel,
  output logic [3:0] hi,
  output logic       ovf
);

  localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

  logic [3:0] q_r;
  logic       co_r;
  logic       co_d;
  logic       ud_r;
  logic       arm;
  logic       co_rise;
  logic [7:0] div;
  logic       idx;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    s = 7'b0000000;
    unique case (v)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      4'hF: s = 7'b1000111;
    endcase
    return s;
  endfunction

  assign co_rise = co_r & ~co_d;

  // input stage; the first edge after reset preloads co_d so a
  // carry already high at release is not seen as an edge
  always_ff @(posedge clk or negedge mr) begin
    if (!mr) begin
      q_r  <= 4'd0;
      co_r <= 1'b0;
      co_d <= 1'b0;
      ud_r <= 1'b0;
      arm  <= 1'b0;
    end else begin
      q_r  <= q_in;
      co_r <= co_in;
      ud_r <= up_dn;
      co_d <= arm ? co_r : co_in;
      arm  <= 1'b1;
    end
  end

  // high digit count and sticky wrap flag; clear wins over a carry
  always_ff @(posedge clk or negedge mr) begin
    if (!mr) begin
      hi  <= 4'd0;
      ovf <= 1'b0;
    end else if (clr) begin
      hi  <= 4'd0;
      ovf <= 1'b0;
    end else if (co_rise) begin
      if (ud_r) begin
        hi <= hi + 4'd1;
        if (hi == 4'hF) ovf <= 1'b1;
      end else begin
        hi <= hi - 4'd1;
        if (hi == 4'h0) ovf <= 1'b1;
      end
    end
  end

  // scan divider; digit index flips every SCAN_DIV clocks
  always_ff @(posedge clk or negedge mr) begin
    if (!mr) begin
      div <= 8'd0;
      idx <= 1'b0;
    end else if (div == DIV_LAST) begin
      div <= 8'd0;
      idx <= ~idx;
    end else begin
      div <= div + 8'd1;
    end
  end

  // registered display drive, segment and enable kept aligned
  always_ff @(posedge clk or negedge mr) begin
    if (!mr) begin
      seg     <= 7'b0000000;
      dig_sel <= 2'b00;
    end else if (idx) begin
      seg     <= hex7(hi);
      dig_sel <= 2'b10;
    end else begin
      seg     <= hex7(q_r);
      dig_sel <= 2'b01;
    end
  end

endmodule

// File: tb/tb_cnt_disp_scan.sv
// Directed bench for cnt_disp_scan: carry edge detect, wrap/sticky,
// clear priority, scan timing, input latency and async reset.
module tb_cnt_disp_scan;

  logic       clk;
  logic       mr;
  logic [3:0] q_in;
  logic       co_in;
  logic       up_dn;
  logic       clr;
  logic [6:0] seg;
  logic [1:0] dig_sel;
  logic [3:0] hi;
  logic       ovf;

  int total = 0;
  int bad   = 0;

  cnt_disp_scan #(.SCAN_DIV(4)) dut (
    .clk(clk), .mr(mr), .q_in(q_in), .co_in(co_in),
    .up_dn(up_dn), .clr(clr), .seg(seg), .dig_sel(dig_sel),
    .hi(hi), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic dir);
    up_dn = dir;
    co_in = 1'b1;
    tick();
    co_in = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    logic [1:0] prev;
    logic [1:0] ds;
    int run;
    bit seen;
    bit found;

    mr = 1'b0; q_in = 4'd0; co_in = 1'b0;
    up_dn = 1'b1; clr = 1'b0;
    #2;
    chk("rst_seg", 32'(seg), 32'h0);
    chk("rst_sel", 32'(dig_sel), 32'h0);
    chk("rst_hi", 32'(hi), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    @(negedge clk);
    mr = 1'b1;
    tick();
    chk("rel_sel", 32'(dig_sel), 32'h1);
    chk("rel_seg", 32'(seg), 32'b1111110);

    // held carry counts once, two edges after sampling
    pulse(1'b1);
    pulse(1'b1);
    chk("hi2", 32'(hi), 32'd2);
    up_dn = 1'b1;
    co_in = 1'b1;
    tick();
    chk("held_e0", 32'(hi), 32'd2);
    tick();
    chk("held_e1", 32'(hi), 32'd3);
    tick(); tick(); tick();
    co_in = 1'b0;
    tick(); tick();
    chk("held_end", 32'(hi), 32'd3);
    chk("held_ovf", 32'(ovf), 32'd0);

    // wrap up, wrap down, sticky, clear
    for (int i = 0; i < 12; i++) pulse(1'b1);
    chk("hi15", 32'(hi), 32'd15);
    chk("ovf_pre", 32'(ovf), 32'd0);
    pulse(1'b1);
    chk("wrap_hi", 32'(hi), 32'd0);
    chk("wrap_ovf", 32'(ovf), 32'd1);
    pulse(1'b0);
    chk("dn_hi", 32'(hi), 32'd15);
    chk("dn_ovf", 32'(ovf), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_hi", 32'(hi), 32'd0);
    chk("clr_ovf", 32'(ovf), 32'd0);

    // clear beats a simultaneous carry edge
    for (int i = 0; i < 7; i++) pulse(1'b1);
    chk("hi7", 32'(hi), 32'd7);
    co_in = 1'b1;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    co_in = 1'b0;
    chk("pri_hi", 32'(hi), 32'd0);
    chk("pri_ovf", 32'(ovf), 32'd0);
    tick(); tick();
    chk("pri_hold", 32'(hi), 32'd0);

    // scan alternation and per-digit decode
    for (int i = 0; i < 10; i++) pulse(1'b1);
    chk("hiA", 32'(hi), 32'hA);
    q_in = 4'd3;
    tick(); tick();
    prev = dig_sel;
    run = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      ds = dig_sel;
      chk("onehot", 32'(ds == 2'b01 || ds == 2'b10), 32'd1);
      chk("scan_seg", 32'(seg),
          (ds == 2'b10) ? 32'b1110111 : 32'b1111001);
      if (ds != prev) begin
        if (seen) chk("run_len", 32'(run), 32'd4);
        seen = 1;
        run = 1;
      end else begin
        run++;
      end
      prev = ds;
    end
    chk("scan_seen", 32'(seen), 32'd1);

    // q_in to seg latency during the low digit
    found = 0;
    prev = dig_sel;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (prev == 2'b10 && dig_sel == 2'b01) found = 1;
      prev = dig_sel;
    end
    chk("lo_start", 32'(found), 32'd1);
    q_in = 4'd7;
    tick();
    chk("lat_e1", 32'(seg), 32'b1111001);
    tick();
    chk("lat_e2", 32'(seg), 32'b1110000);
    chk("lat_sel", 32'(dig_sel), 32'h1);

    // async reset mid-carry, carry held across release
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 11; i++) pulse(1'b0);
    chk("hi5", 32'(hi), 32'd5);
    chk("ovf5", 32'(ovf), 32'd1);
    @(negedge clk);
    up_dn = 1'b1;
    co_in = 1'b1;
    mr = 1'b0;
    #1;
    chk("ar_seg", 32'(seg), 32'h0);
    chk("ar_sel", 32'(dig_sel), 32'h0);
    chk("ar_hi", 32'(hi), 32'h0);
    chk("ar_ovf", 32'(ovf), 32'h0);
    tick(); tick();
    @(negedge clk);
    mr = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("ar_hold", 32'(hi), 32'd0);
    co_in = 1'b0;
    tick(); tick();
    chk("ar_final", 32'(hi), 32'd0);
    chk("ar_fovf", 32'(ovf), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
